matmul_apb_master: RTL and testbench

- Synthesizable APB master sequencer that turns burst commands into APB transfers toward the matmul register space. Typical bursts: load operand rows at a stride, write the control register, read back result elements.
- Replaces hand-driven APB stimulus, and adds bursts, wait-state handling, error reporting and a pready timeout.
- Sits between a host/DMA command source and the matmul APB slave port.

---
 rtl/matmul_apb_pkg.sv | 16 +
 rtl/apb_timeout_cnt.sv | 37 +++
 rtl/matmul_apb_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_matmul_apb_master.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_apb_pkg.sv
// Shared definitions for the matmul APB master sequencer and the matmul slave.
// Holds the sequencer state encoding and the default stride and timeout values.
package matmul_apb_pkg;

    localparam int STRIDE_SHIFT_DEF = 5;
    localparam int TIMEOUT_DEF      = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting on pready; expired_o fires on the
// TIMEOUT-th stalled cycle so the caller can abort in that same cycle.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matmul_apb_master.sv
// Burst command to APB transfer sequencer for the matmul register space,
// with wait-state handling, pslverr reporting and a pready timeout.
module matmul_apb_master
    import matmul_apb_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_BURST    = 16,
    parameter int STRIDE_SHIFT = STRIDE_SHIFT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
    input  logic [$clog2(MAX_BURST)-1:0]   cmd_len_i,
    input  logic [BUS_WIDTH/8-1:0]         cmd_strb_i,
    input  logic                           wdata_valid_i,
    output logic                           wdata_ready_o,
    input  logic [BUS_WIDTH-1:0]           wdata_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [BUS_WIDTH-1:0]           rsp_data_o,
    output logic                           rsp_err_o,
    output logic                           rsp_last_o,
    output logic                           psel_o,
    output logic                           penable_o,
    output logic                           pwrite_o,
    output logic [ADDR_WIDTH-1:0]          paddr_o,
    output logic [BUS_WIDTH-1:0]           pwdata_o,
    output logic [BUS_WIDTH/8-1:0]         pstrb_o,
    input  logic [BUS_WIDTH-1:0]           prdata_i,
    input  logic                           pready_i,
    input  logic                           pslverr_i,
    output logic                           busy_o
);

    localparam int LEN_W = $clog2(MAX_BURST);
    localparam int SW    = BUS_WIDTH / 8;

    apb_state_e state_q, state_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wdata_ready_q, wdata_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  busy_q, busy_d;

    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    logic                  err_acc_q, err_acc_d;

    logic                  last_beat;
    logic [LEN_W-1:0]      beat_inc;
    logic                  tmo_expired;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [LEN_W-1:0] beat);
        return base + (ADDR_WIDTH'(beat) << STRIDE_SHIFT);
    endfunction

    assign last_beat = (beat_q == len_q);
    assign beat_inc  = beat_q + LEN_W'(1);

    // The timer restarts for every transfer, so wait states never accumulate across beats.
    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (state_q != ACCESS),
        .enable_i  ((state_q == ACCESS) && !pready_i),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_last_d = rsp_last_q;
        write_d    = write_q;
        base_d     = base_q;
        len_d      = len_q;
        strb_d     = strb_q;
        beat_d     = beat_q;
        err_acc_d  = err_acc_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    write_d   = cmd_write_i;
                    base_d    = cmd_addr_i;
                    len_d     = cmd_len_i;
                    strb_d    = cmd_strb_i;
                    beat_d    = '0;
                    err_acc_d = 1'b0;
                    if (cmd_write_i) begin
                        state_d = WDATA;
                    end else begin
                        state_d  = SETUP;
                        pwrite_d = 1'b0;
                        paddr_d  = cmd_addr_i;
                        pwdata_d = '0;
                        pstrb_d  = '0;
                    end
                end
            end
            WDATA: begin
                if (wdata_valid_i) begin
                    state_d  = SETUP;
                    pwrite_d = 1'b1;
                    paddr_d  = beat_addr(base_q, beat_q);
                    pwdata_d = wdata_i;
                    pstrb_d  = strb_q;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    err_acc_d = err_acc_q | pslverr_i;
                    if (!write_q) begin
                        state_d    = RESP;
                        rsp_data_d = prdata_i;
                        rsp_err_d  = pslverr_i;
                        rsp_last_d = last_beat;
                    end else if (!last_beat) begin
                        state_d = WDATA;
                        beat_d  = beat_inc;
                    end else begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = err_acc_q | pslverr_i;
                        rsp_last_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    // Abandon the rest of the burst; the single error response closes it.
                    state_d    = RESP;
                    err_acc_d  = 1'b1;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_last_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    rsp_last_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SETUP;
                        beat_d  = beat_inc;
                        paddr_d = beat_addr(base_q, beat_inc);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake and APB control outputs are pure functions of the next state.
        cmd_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WDATA);
        psel_d        = (state_d == SETUP) || (state_d == ACCESS);
        penable_d     = (state_d == ACCESS);
        rsp_valid_d   = (state_d == RESP);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            write_q       <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            strb_q        <= '0;
            beat_q        <= '0;
            err_acc_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            wdata_ready_q <= wdata_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_last_q    <= rsp_last_d;
            busy_q        <= busy_d;
            write_q       <= write_d;
            base_q        <= base_d;
            len_q         <= len_d;
            strb_q        <= strb_d;
            beat_q        <= beat_d;
            err_acc_q     <= err_acc_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign wdata_ready_o = wdata_ready_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_last_o    = rsp_last_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed and randomized bursts against an APB slave model, with expected
// transfers and responses derived from the burst rules by plain arithmetic.
module tb_matmul_apb_master;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } xfer_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        logic          last;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [3:0]    cmd_len_i;
    logic [SW-1:0] cmd_strb_i;
    logic          wdata_valid_i, wdata_ready_o;
    logic [DW-1:0] wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_last_o;
    logic [DW-1:0] rsp_data_o;
    logic          psel_o, penable_o, pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i, pslverr_i;
    logic          busy_o;

    matmul_apb_master #(
        .BUS_WIDTH    (DW),
        .ADDR_WIDTH   (AW),
        .MAX_BURST    (16),
        .STRIDE_SHIFT (5),
        .TIMEOUT      (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_len_i     (cmd_len_i),
        .cmd_strb_i    (cmd_strb_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .wdata_i       (wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_last_o    (rsp_last_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // per-command configuration of the slave and the host side
    int            slv_wait[16];
    logic          slv_err[16];
    int            wstall[16];
    int            rstall[16];
    logic [DW-1:0] wd[16];
    int            hang_beat;

    // slave / monitor state
    int            acc_cnt, beat_idx, wbeat, wwait, rwait, proto_bad, psel_cycles;
    int            first_rsp_cyc, hs_cyc;
    logic [DW-1:0] rd_salt;
    xfer_t         tr_q[$];
    int            tr_acc[$];
    rsp_t          rs_q[$];
    logic [DW-1:0] wq[$];
    xfer_t         exp_tr[$];
    rsp_t          exp_rs[$];
    logic          prev_psel = 1'b0;
    xfer_t         prev_x;
    logic          prev_rsp_hold = 1'b0;
    rsp_t          prev_rsp;
    logic [127:0]  rst_outs;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdval(input logic [AW-1:0] a);
        return {a, a ^ 16'hA5C3} ^ rd_salt;
    endfunction

    function automatic logic [127:0] outs();
        return {35'd0, cmd_ready_o, wdata_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o,
                psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, busy_o};
    endfunction

    // One clock: sample DUT just after the edge, check protocol, then drive slave/host inputs.
    task automatic step();
        xfer_t cur_x;
        rsp_t  cur_r;
        @(posedge clk_i);
        #1;
        cyc++;
        cur_x = '{wr: pwrite_o, addr: paddr_o, data: pwdata_o, strb: pstrb_o};
        cur_r = '{data: rsp_data_o, err: rsp_err_o, last: rsp_last_o};
        if (psel_o) psel_cycles++;
        if (psel_o && penable_o && !prev_psel) proto_bad++;
        if (psel_o && !penable_o && prev_psel) proto_bad++;
        if (psel_o && penable_o && prev_psel && (cur_x !== prev_x)) proto_bad++;
        if (penable_o && !psel_o) proto_bad++;
        if (psel_o && (wdata_ready_o || rsp_valid_o)) proto_bad++;
        if (prev_rsp_hold && (!rsp_valid_o || cur_r !== prev_rsp)) proto_bad++;
        if (rsp_valid_o && first_rsp_cyc < 0) first_rsp_cyc = cyc;

        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = $urandom;
        if (psel_o && penable_o) begin
            if (beat_idx != hang_beat && acc_cnt >= slv_wait[beat_idx % 16]) begin
                pready_i  = 1'b1;
                pslverr_i = slv_err[beat_idx % 16];
                prdata_i  = rdval(paddr_o);
                tr_q.push_back(cur_x);
                tr_acc.push_back(acc_cnt + 1);
                beat_idx++;
                acc_cnt = 0;
            end else begin
                acc_cnt++;
            end
        end

        wdata_valid_i = 1'b0;
        wdata_i       = $urandom;
        if (wq.size() > 0 && wdata_ready_o) begin
            if (wwait < wstall[wbeat % 16]) begin
                wwait++;
            end else begin
                wdata_valid_i = 1'b1;
                wdata_i       = wq.pop_front();
                wbeat++;
                wwait = 0;
            end
        end

        rsp_ready_i = 1'b0;
        if (rsp_valid_o) begin
            if (rwait < rstall[rs_q.size() % 16]) begin
                rwait++;
            end else begin
                rsp_ready_i = 1'b1;
                rs_q.push_back(cur_r);
                rwait = 0;
            end
        end

        prev_psel     = psel_o;
        prev_x        = cur_x;
        prev_rsp_hold = rsp_valid_o && !rsp_ready_i;
        prev_rsp      = cur_r;
    endtask

    task automatic clear_cfg();
        for (int b = 0; b < 16; b++) begin
            slv_wait[b] = 0;
            slv_err[b]  = 1'b0;
            wstall[b]   = 0;
            rstall[b]   = 0;
            wd[b]       = $urandom;
        end
        hang_beat = -1;
    endtask

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [3:0] len,
                             input logic [SW-1:0] strb);
        int    n, n_beats, stop;
        logic  hs, err_or;
        xfer_t x;
        rsp_t  r;
        tr_q.delete(); tr_acc.delete(); rs_q.delete(); wq.delete();
        exp_tr.delete(); exp_rs.delete();
        acc_cnt = 0; beat_idx = 0; wbeat = 0; wwait = 0; rwait = 0;
        proto_bad = 0; first_rsp_cyc = -1; hs_cyc = -1;
        rd_salt = $urandom;

        // Reference: beat b goes to addr + 32*b mod 2^16; a hung beat ends the burst with one error.
        n_beats = int'(len) + 1;
        stop    = (hang_beat >= 0 && hang_beat < n_beats) ? hang_beat : n_beats;
        err_or  = 1'b0;
        for (int b = 0; b < n_beats; b++) if (wr) wq.push_back(wd[b]);
        for (int b = 0; b < stop; b++) begin
            x.wr   = wr;
            x.addr = addr + 16'(b * 32);
            x.data = wr ? wd[b] : '0;
            x.strb = wr ? strb : '0;
            exp_tr.push_back(x);
            err_or = err_or | slv_err[b];
            if (!wr) begin
                r = '{data: rdval(x.addr), err: slv_err[b], last: (b == n_beats - 1)};
                exp_rs.push_back(r);
            end
        end
        if (stop < n_beats) begin
            r = '{data: '0, err: 1'b1, last: 1'b1};
            exp_rs.push_back(r);
        end else if (wr) begin
            r = '{data: '0, err: err_or, last: 1'b1};
            exp_rs.push_back(r);
        end

        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_strb_i  = strb;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            hs = cmd_ready_o;
            if (hs) hs_cyc = cyc;
            step();
            n++;
        end
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 16'($urandom);
        check("cmd_accept", hs, 1);
        if (hs) begin
            if (wr) check("first_cycle_wdata", {wdata_ready_o, psel_o}, 2'b10);
            else    check("first_cycle_setup", {psel_o, penable_o}, 2'b10);
        end
    endtask

    task automatic finish_cmd(input string tag, input int budget);
        int   n, snap;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            done = (rs_q.size() > 0) && rs_q[rs_q.size() - 1].last && !busy_o;
            if (!done) begin
                step();
                n++;
            end
        end
        check($sformatf("%s_done", tag), done, 1);
        snap = psel_cycles;
        repeat (4) step();
        check($sformatf("%s_quiet", tag), psel_cycles - snap, 0);
        check($sformatf("%s_xfer_cnt", tag), tr_q.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < tr_q.size(); i++) begin
            check($sformatf("%s_xfer%0d_ctl", tag, i), {tr_q[i].wr, tr_q[i].addr, tr_q[i].strb},
                  {exp_tr[i].wr, exp_tr[i].addr, exp_tr[i].strb});
            if (exp_tr[i].wr) check($sformatf("%s_xfer%0d_wdata", tag, i), tr_q[i].data, exp_tr[i].data);
        end
        check($sformatf("%s_rsp_cnt", tag), rs_q.size(), exp_rs.size());
        for (int i = 0; i < exp_rs.size() && i < rs_q.size(); i++) begin
            check($sformatf("%s_rsp%0d", tag, i), rs_q[i], exp_rs[i]);
        end
        check($sformatf("%s_protocol", tag), proto_bad, 0);
        $display("txn %s: xfers=%0d rsps=%0d expected_xfers=%0d expected_rsps=%0d",
                 tag, tr_q.size(), rs_q.size(), exp_tr.size(), exp_rs.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, ok;
        logic wr;
        logic [3:0] len;
        rst_outs      = 128'd1 << 92;
        rst_n_i       = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_write_i   = 1'b0;
        cmd_addr_i    = '0;
        cmd_len_i     = '0;
        cmd_strb_i    = '0;
        wdata_valid_i = 1'b0;
        wdata_i       = '0;
        rsp_ready_i   = 1'b0;
        prdata_i      = '0;
        pready_i      = 1'b0;
        pslverr_i     = 1'b0;
        clear_cfg();

        // reset state
        #2 rst_n_i = 1'b0;
        #2 check("reset_outputs", outs(), rst_outs);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        step();
        check("idle_after_reset", outs(), rst_outs);

        // write burst, zero wait states
        clear_cfg();
        wd[0] = 32'h04030201; wd[1] = 32'h08070605; wd[2] = 32'h0C0B0A09; wd[3] = 32'h100F0E0D;
        issue_cmd(1'b1, 16'h0004, 4'd3, 4'hF);
        finish_cmd("wr_burst", 200);
        if (tr_q.size() == 4) check("wr_burst_addr3", tr_q[3].addr, 16'h0064);

        // full-length read burst with 2 wait states on beat 5
        clear_cfg();
        slv_wait[5] = 2;
        issue_cmd(1'b0, 16'h0010, 4'd15, 4'hF);
        finish_cmd("rd_wait", 400);
        check("rd_latency", first_rsp_cyc - hs_cyc, 3);
        ok = 1;
        for (int i = 0; i < tr_acc.size(); i++) if (tr_acc[i] != ((i == 5) ? 3 : 1)) ok = 0;
        check("rd_wait_penable_len", ok, 1);
        if (tr_acc.size() > 5) check("rd_wait_beat5_penable", tr_acc[5], 3);

        // slave errors do not abort
        clear_cfg();
        slv_err[2] = 1'b1;
        issue_cmd(1'b0, 16'h0200, 4'd3, 4'h0);
        finish_cmd("rd_slverr", 200);
        clear_cfg();
        slv_err[1] = 1'b1;
        issue_cmd(1'b1, 16'h0300, 4'd3, 4'h5);
        finish_cmd("wr_slverr", 200);

        // timeout on beat 0 of a read
        clear_cfg();
        hang_beat = 0;
        issue_cmd(1'b0, 16'h0400, 4'd3, 4'h0);
        finish_cmd("rd_timeout", 200);
        check("rd_timeout_access_cycles", acc_cnt, TMO);
        check("rd_timeout_busy", busy_o, 0);

        // timeout mid write burst
        clear_cfg();
        hang_beat = 2;
        issue_cmd(1'b1, 16'h0500, 4'd3, 4'h3);
        finish_cmd("wr_timeout", 200);

        // backpressure: wdata stall mid-burst, response stall
        clear_cfg();
        wstall[2] = 3;
        rstall[0] = 4;
        issue_cmd(1'b1, 16'h0600, 4'd3, 4'hC);
        finish_cmd("wr_stall", 200);
        clear_cfg();
        rstall[1] = 4;
        issue_cmd(1'b0, 16'h0700, 4'd3, 4'h0);
        finish_cmd("rd_stall", 200);

        // address wrap at the top of the space
        clear_cfg();
        issue_cmd(1'b1, 16'hFFC0, 4'd3, 4'hF);
        finish_cmd("wr_wrap", 200);

        // asynchronous reset during ACCESS of beat 1
        clear_cfg();
        hang_beat = 1;
        issue_cmd(1'b0, 16'h0100, 4'd3, 4'h0);
        n = 0;
        while (!(psel_o && penable_o && beat_idx == 1 && acc_cnt >= 2) && n < 100) begin
            step();
            n++;
        end
        check("rst_reach_access", {psel_o, penable_o, beat_idx == 1}, 3'b111);
        #2 rst_n_i = 1'b0;
        #1 check("rst_async_outputs", outs(), rst_outs);
        @(posedge clk_i);
        #1 check("rst_held_outputs", outs(), rst_outs);
        rst_n_i = 1'b1;
        step();
        step();
        check("rst_release_outputs", outs(), rst_outs);
        clear_cfg();
        slv_wait[1] = 1;
        issue_cmd(1'b0, 16'h0120, 4'd2, 4'h0);
        finish_cmd("post_rst_rd", 200);
        clear_cfg();
        issue_cmd(1'b1, 16'h0140, 4'd1, 4'h9);
        finish_cmd("post_rst_wr", 200);

        // randomized bursts
        for (int t = 0; t < 20; t++) begin
            clear_cfg();
            wr  = 1'($urandom_range(0, 1));
            len = 4'($urandom);
            for (int b = 0; b < 16; b++) begin
                slv_wait[b] = $urandom_range(0, 3);
                slv_err[b]  = ($urandom_range(0, 7) == 0);
                wstall[b]   = $urandom_range(0, 2);
                rstall[b]   = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 7) == 0) hang_beat = $urandom_range(0, int'(len));
            issue_cmd(wr, 16'($urandom), len, 4'($urandom));
            finish_cmd($sformatf("rnd%0d", t), 800);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
